sys_output_collector: RTL and testbench

Receive-side companion to the `systolic` array. Captures the per-column results leaving the bottom edge of the array (`sys_data_out_2x` / `sys_valid_out_2x`), which arrive diagonally skewed by one cycle per column. The block de-skews them into whole result rows and buffers the rows in a small FIFO. Rows are handed downstream (unified buffer / activation stage) over a valid/ready handshake, with a start/done job wrapper around a known row count.

---
 rtl/tpu_pkg.sv | 17 +
 rtl/sys_output_collector_if.sv | 31 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/sys_output_collector.sv | 187 ++++++++++++++++++
 tb/tb_sys_output_collector.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: Q8.8 fixed-point type and constants, and the
// state encoding of the systolic output collector.
package tpu_pkg;

    typedef logic signed [15:0] fixed16_t;

    localparam int       FRAC_BITS = 8;
    localparam fixed16_t FIXED_ONE = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } collector_state_t;

endpackage

// File: rtl/sys_output_collector_if.sv
// Column-in / row-out bus of the systolic output collector.
// The slave modport is the collector; the master modport is its environment
// (array bottom edge driving columns, downstream stage driving row_ready).
interface sys_output_collector_if #(
    parameter int N_COLS = 2,
    parameter int DATA_W = 16
) ();

    logic [N_COLS*DATA_W-1:0] col_data_in;
    logic [N_COLS-1:0]        col_valid_in;
    logic [N_COLS*DATA_W-1:0] row_data;
    logic                     row_valid;
    logic                     row_ready;

    modport master (
        output col_data_in,
        output col_valid_in,
        output row_ready,
        input  row_data,
        input  row_valid
    );

    modport slave (
        input  col_data_in,
        input  col_valid_in,
        input  row_ready,
        output row_data,
        output row_valid
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead output. A push into a full FIFO is
// accepted when a pop happens in the same cycle. No empty-FIFO bypass: a
// pushed word becomes visible on pop_data the cycle after the push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_reg] <= push_data;
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sys_output_collector.sv
// Systolic array output collector: de-skews the diagonally arriving column
// results into whole rows, checks alignment, buffers rows in a FIFO and runs a
// start/done job over a known row count.
// Optional feature macro: COLLECTOR_RELU_EN (clamp negative elements to zero
// as rows are pushed into the FIFO).
module sys_output_collector
    import tpu_pkg::*;
#(
    parameter int N_COLS = 2,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  rows_expected,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err,
    sys_output_collector_if.slave bus
);

    localparam int ROW_W = N_COLS * DATA_W;

    logic [N_COLS-1:0] aligned_valid;
    logic [ROW_W-1:0]  aligned_data;
    logic [N_COLS-1:0] stage_valid_reg;
    logic [ROW_W-1:0]  stage_data_reg;
    logic [ROW_W-1:0]  push_data;

    collector_state_t  state_reg, state_next;
    logic [CNT_W-1:0]  rows_exp_reg, rows_exp_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  count_inc;
    logic [2:0]        err_reg, err_next;

    logic row_complete;
    logic flag_skew;
    logic flag_overflow;
    logic flag_unexpected;
    logic push_req;
    logic push_accept;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    genvar gi;

    // Column j is held back N_COLS-1-j cycles so all columns of a row line up
    // with the last (undelayed) column.
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_deskew
            localparam int STAGES = N_COLS - 1 - gi;
            if (STAGES == 0) begin : g_direct
                assign aligned_valid[gi]                 = bus.col_valid_in[gi];
                assign aligned_data[gi*DATA_W +: DATA_W] = bus.col_data_in[gi*DATA_W +: DATA_W];
            end else begin : g_delay
                logic [STAGES-1:0] valid_reg;
                logic [DATA_W-1:0] data_reg [STAGES];
                // Shift register carrying this column's valid and data.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg <= '0;
                        for (int k = 0; k < STAGES; k++) begin
                            data_reg[k] <= '0;
                        end
                    end else begin
                        valid_reg[0] <= bus.col_valid_in[gi];
                        data_reg[0]  <= bus.col_data_in[gi*DATA_W +: DATA_W];
                        for (int k = 1; k < STAGES; k++) begin
                            valid_reg[k] <= valid_reg[k-1];
                            data_reg[k]  <= data_reg[k-1];
                        end
                    end
                end
                assign aligned_valid[gi]                 = valid_reg[STAGES-1];
                assign aligned_data[gi*DATA_W +: DATA_W] = data_reg[STAGES-1];
            end
        end
    endgenerate

    // Push stage: the aligned row is registered once and judged here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid_reg <= '0;
            stage_data_reg  <= '0;
        end else begin
            stage_valid_reg <= aligned_valid;
            stage_data_reg  <= aligned_data;
        end
    end

    // Element-wise ReLU on the way into the FIFO (combinational, no extra cycle).
    generate
        for (gi = 0; gi < N_COLS; gi++) begin : g_relu
`ifdef COLLECTOR_RELU_EN
            assign push_data[gi*DATA_W +: DATA_W] = stage_data_reg[gi*DATA_W + DATA_W - 1]
                                                    ? '0 : stage_data_reg[gi*DATA_W +: DATA_W];
`else
            assign push_data[gi*DATA_W +: DATA_W] = stage_data_reg[gi*DATA_W +: DATA_W];
`endif
        end
    endgenerate

    assign row_complete    = &stage_valid_reg;
    assign flag_skew       = (|stage_valid_reg) && !row_complete;
    assign push_req        = row_complete && (state_reg == ST_COLLECT);
    assign pop             = bus.row_ready && !fifo_empty;
    assign push_accept     = push_req && (!fifo_full || pop);
    assign flag_overflow   = push_req && !push_accept;
    assign flag_unexpected = (row_complete && (state_reg != ST_COLLECT))
                           || ((state_reg == ST_IDLE) && (|bus.col_valid_in));
    assign count_inc       = count_reg + 1'b1;

    sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_accept),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (bus.row_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.row_valid = !fifo_empty;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign err           = err_reg;

    // Job state, latched row target, row counter and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            rows_exp_reg <= '0;
            count_reg    <= '0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            rows_exp_reg <= rows_exp_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic; dropped (overflowed) rows still count so jobs always end.
    always_comb begin
        state_next    = state_reg;
        rows_exp_next = rows_exp_reg;
        count_next    = count_reg;
        err_next      = err_reg | {flag_unexpected, flag_overflow, flag_skew};
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    rows_exp_next = rows_expected;
                    count_next    = '0;
                    err_next      = '0;
                    state_next    = (rows_expected == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (row_complete) begin
                    count_next = count_inc;
                    if (count_inc == rows_exp_reg) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_output_collector.sv
// Directed test of sys_output_collector with a row scoreboard: stimulus
// queues the expected rows, a negedge monitor pops and compares every row
// accepted downstream.
module tb_sys_output_collector;
    import tpu_pkg::*;

    localparam int N_COLS = 2;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] rows_expected = '0;
    logic             busy;
    logic             done;
    logic [2:0]       err;

    sys_output_collector_if #(.N_COLS(N_COLS), .DATA_W(DATA_W)) bus ();

    sys_output_collector #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rows_expected (rows_expected),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rows   = 0;
    logic [31:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] held_data = '0;
    logic [15:0] feed0 [8];
    logic [15:0] feed1 [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: row stability under backpressure and row contents on each pop.
    always @(negedge clk) begin
        if (hold_pending && bus.row_valid) begin
            check("row_hold", bus.row_data, held_data);
        end
        if (bus.row_valid && bus.row_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL row_unexpected: got %h, no row expected", bus.row_data);
            end else begin
                logic [31:0] exp_row;
                exp_row = exp_q.pop_front();
                $display("row %0d: got %h expected %h", n_rows, bus.row_data, exp_row);
                check("row_data", bus.row_data, exp_row);
                n_rows++;
            end
        end
        hold_pending = bus.row_valid && !bus.row_ready;
        held_data    = bus.row_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input logic v0, input logic [15:0] d0, input logic v1, input logic [15:0] d1);
        bus.col_valid_in = {v1, v0};
        bus.col_data_in  = {d1, d0};
    endtask

    task automatic start_job(input logic [CNT_W-1:0] n);
        step();
        start         = 1'b1;
        rows_expected = n;
        step();
        start = 1'b0;
    endtask

    // Feeds n rows with column 1 trailing column 0 by one cycle.
    task automatic feed_rows(input int n, input bit check_lat);
        for (int k = 0; k <= n; k++) begin
            step();
            set_cols(k < n, (k < n) ? feed0[k] : 16'h0, k >= 1, (k >= 1) ? feed1[k-1] : 16'h0);
            if (check_lat) begin
                @(negedge clk);
                check("row_valid_latency", {31'b0, bus.row_valid}, {31'b0, (k >= 3)});
            end
        end
        step();
        set_cols(1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic wait_done(input int max_cyc, input logic [2:0] exp_err, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done: got no done pulse, expected one within %0d cycles", tag, max_cyc);
        end else begin
            $display("%s: done seen, err=%b", tag, err);
            check({tag, "_err"}, {29'b0, err}, {29'b0, exp_err});
            check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
            check({tag, "_rows_delivered"}, exp_q.size(), 32'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
            check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        int hi;
        bus.col_valid_in = '0;
        bus.col_data_in  = '0;
        bus.row_ready    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row_data", bus.row_data, 32'h0);
        check("rst_row_valid", {31'b0, bus.row_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {29'b0, err}, 32'd0);
        step();
        rst = 1'b1;

        // Column valids while idle: err[2], nothing stored
        feed0[0] = 16'h0A00;
        feed1[0] = 16'h0B00;
        feed_rows(1, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_valid_err", {29'b0, err}, {29'b0, 3'b100});
        check("idle_valid_no_row", {31'b0, bus.row_valid}, 32'd0);
        check("idle_valid_busy", {31'b0, busy}, 32'd0);

        // Identity-weight pass: rows {1,2},{3,4},{5,6},{7,8}
        bus.row_ready = 1'b1;
        start_job(8'd4);
        @(negedge clk);
        check("start_clears_err", {29'b0, err}, 32'd0);
        check("busy_rise", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            feed0[i] = 16'((2*i + 1) << 8);
            feed1[i] = 16'((2*i + 2) << 8);
            exp_q.push_back({feed1[i], feed0[i]});
        end
        feed_rows(4, 1'b1);
        wait_done(30, 3'b000, "ident");

        // Backpressure with overflow of the fifth row
        bus.row_ready = 1'b0;
        start_job(8'd5);
        for (int i = 0; i < 5; i++) begin
            feed0[i] = 16'(16'h1100 + (i << 12));
            feed1[i] = 16'(16'h1200 + (i << 12));
            if (i < 4) exp_q.push_back({feed1[i], feed0[i]});
        end
        feed_rows(5, 1'b0);
        hi = 0;
        for (int i = 0; i < 60 && hi < 10; i++) begin
            @(negedge clk);
            if (bus.row_valid) hi++;
        end
        check("bp_valid_held", hi, 32'd10);
        check("bp_overflow_flag", {29'b0, err}, {29'b0, 3'b010});
        check("bp_busy", {31'b0, busy}, 32'd1);
        step();
        bus.row_ready = 1'b1;
        wait_done(40, 3'b010, "bp");

        // Skew violation: column 1 two cycles late
        start_job(8'd1);
        step();
        set_cols(1'b1, 16'h1111, 1'b0, 16'h0);
        step();
        set_cols(1'b0, 16'h0, 1'b0, 16'h0);
        step();
        set_cols(1'b0, 16'h0, 1'b1, 16'h2222);
        step();
        set_cols(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (4) @(negedge clk);
        check("skew_err", {29'b0, err}, {29'b0, 3'b001});
        check("skew_no_row", {31'b0, bus.row_valid}, 32'd0);
        check("skew_still_busy", {31'b0, busy}, 32'd1);
        feed0[0] = 16'h0300;
        feed1[0] = 16'h0400;
        exp_q.push_back({feed1[0], feed0[0]});
        feed_rows(1, 1'b0);
        wait_done(30, 3'b001, "skew");

        // ReLU row {-0.5, 1.0}
        start_job(8'd1);
        feed0[0] = 16'hFF80;
        feed1[0] = FIXED_ONE;
`ifdef COLLECTOR_RELU_EN
        exp_q.push_back({16'h0100, 16'h0000});
`else
        exp_q.push_back({16'h0100, 16'hFF80});
`endif
        feed_rows(1, 1'b0);
        wait_done(30, 3'b000, "relu");

        // Reset mid-job after two of four rows are stored
        bus.row_ready = 1'b0;
        start_job(8'd4);
        feed0[0] = 16'h0700; feed1[0] = 16'h0800;
        feed0[1] = 16'h0900; feed1[1] = 16'h0A00;
        feed_rows(2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_valid", {31'b0, bus.row_valid}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_row_valid", {31'b0, bus.row_valid}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_row_data", bus.row_data, 32'h0);
        step();
        rst = 1'b1;
        bus.row_ready = 1'b1;
        start_job(8'd1);
        feed0[0] = 16'h0500;
        feed1[0] = 16'h0600;
        exp_q.push_back({feed1[0], feed0[0]});
        feed_rows(1, 1'b0);
        wait_done(30, 3'b000, "post_rst");

        // Zero-row job
        step();
        start         = 1'b1;
        rows_expected = 8'd0;
        @(negedge clk);
        check("zero_busy_before", {31'b0, busy}, 32'd0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_busy", {31'b0, busy}, 32'd1);
        check("zero_done", {31'b0, done}, 32'd1);
        step();
        @(negedge clk);
        check("zero_busy_fall", {31'b0, busy}, 32'd0);
        check("zero_done_fall", {31'b0, done}, 32'd0);
        check("zero_no_row", {31'b0, bus.row_valid}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
